// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the Memoria arbiter.
//            - arb_state_t : arbiter FSM states (IDLE, ACCESS, DONE)
//            - PORT_CPU / PORT_DBG : requester indices as seen on Grant
//            - LAT_W : width of the read-latency counter (READ_LAT <= 7)
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int LAT_W = 3;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin arbiter and access sequencer in front of the
//            single-port Memoria. Port 0 is the CPU datapath, port 1 the
//            loader/debug port. One access at a time; read data is
//            registered per port and completion is a one-cycle Ack.
// Ports    : Clk, Reset (async, active low)
//            Req*/Wr*/Addr*/WData*  - requester inputs, ports 0 and 1
//            Ack*/RData*            - completion pulse and read data
//            MemAddress/MemWr/MemDatain/MemDataout - Memoria side
//            Busy  - FSM not in IDLE
//            Grant - owner of the current or most recent transaction
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int READ_LAT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req0,
  input  logic        Req1,
  input  logic        Wr0,
  input  logic        Wr1,
  input  logic [31:0] Addr0,
  input  logic [31:0] Addr1,
  input  logic [31:0] WData0,
  input  logic [31:0] WData1,
  output logic        Ack0,
  output logic        Ack1,
  output logic [31:0] RData0,
  output logic [31:0] RData1,
  output logic [31:0] MemAddress,
  output logic        MemWr,
  output logic [31:0] MemDatain,
  input  logic [31:0] MemDataout,
  output logic        Busy,
  output logic        Grant
);

  localparam logic [1:0] c_IDLE   = ST_IDLE;
  localparam logic [1:0] c_ACCESS = ST_ACCESS;
  localparam logic [1:0] c_DONE   = ST_DONE;

  // Counter value in the last ACCESS cycle of a read.
  localparam logic [LAT_W-1:0] c_LAST = LAT_W'(READ_LAT - 1);

  logic [1:0]       r_state;
  logic [LAT_W-1:0] r_cnt;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_wr;
  logic             r_grant;
  logic             r_lastGrant;
  logic [31:0]      r_rdata0;
  logic [31:0]      r_rdata1;
  logic             w_pick;

  // Port 1 wins when it is the only requester, or on a tie when port 0
  // owned the previous transaction.
  assign w_pick = Req1 & (~Req0 | ~r_lastGrant);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= c_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wr        <= 1'b0;
      r_grant     <= 1'b0;
      r_lastGrant <= 1'b1;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_cnt <= '0;
          if (Req0 | Req1) begin
            r_grant     <= w_pick;
            r_lastGrant <= w_pick;
            r_addr      <= w_pick ? Addr1  : Addr0;
            r_wdata     <= w_pick ? WData1 : WData0;
            r_wr        <= w_pick ? Wr1    : Wr0;
            r_state     <= c_ACCESS;
          end
        end
        c_ACCESS: begin
          if (r_wr) begin
            r_state <= c_DONE;
          end else if (r_cnt == c_LAST) begin
            if (r_grant == PORT_DBG) begin
              r_rdata1 <= MemDataout;
            end else begin
              r_rdata0 <= MemDataout;
            end
            r_state <= c_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Outputs are decodes of registered state only; the async reset forces
  // r_state to IDLE, so MemWr falls without waiting for a clock edge.
  assign MemAddress = r_addr;
  assign MemDatain  = r_wdata;
  assign MemWr      = (r_state == c_ACCESS) & r_wr;
  assign Busy       = (r_state != c_IDLE);
  assign Grant      = r_grant;
  assign Ack0       = (r_state == c_DONE) & (r_grant == PORT_CPU);
  assign Ack1       = (r_state == c_DONE) & (r_grant == PORT_DBG);
  assign RData0     = r_rdata0;
  assign RData1     = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter with READ_LAT = 2
//            and a small Memoria model (one registered read stage, so data
//            for an address presented in ACCESS cycle 1 is valid in cycle 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int READ_LAT = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Req0 = 1'b0, Req1 = 1'b0, Wr0 = 1'b0, Wr1 = 1'b0;
  logic [31:0] Addr0 = '0, Addr1 = '0, WData0 = '0, WData1 = '0;
  logic        Ack0, Ack1, MemWr, Busy, Grant;
  logic [31:0] RData0, RData1, MemAddress, MemDatain;
  logic [31:0] memDataout = '0;

  // Memory model with a backdoor write port used for preloading.
  logic [31:0] mem [0:255];
  logic        bdWe = 1'b0;
  logic [7:0]  bdAddr = '0;
  logic [31:0] bdData = '0;

  int nChecks = 0;
  int nFails  = 0;

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (bdWe) mem[bdAddr] <= bdData;
    else if (MemWr) mem[MemAddress[9:2]] <= MemDatain;
    memDataout <= mem[MemAddress[9:2]];
  end

  mem_arbiter #(.READ_LAT(READ_LAT)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .Wr0(Wr0), .Wr1(Wr1),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Ack0(Ack0), .Ack1(Ack1), .RData0(RData0), .RData1(RData1),
    .MemAddress(MemAddress), .MemWr(MemWr), .MemDatain(MemDatain),
    .MemDataout(memDataout), .Busy(Busy), .Grant(Grant)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; drive and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    bdWe = 1'b1; bdAddr = a[9:2]; bdData = d;
    tick();
    bdWe = 1'b0;
  endtask

  int nAck;

  initial begin
    // ---------------- reset ----------------
    tick(); tick();
    checkVal("rst_ack0", {31'd0, Ack0}, 0);
    checkVal("rst_ack1", {31'd0, Ack1}, 0);
    checkVal("rst_busy", {31'd0, Busy}, 0);
    checkVal("rst_memwr", {31'd0, MemWr}, 0);
    checkVal("rst_addr", MemAddress, 0);
    checkVal("rst_datain", MemDatain, 0);
    checkVal("rst_rdata0", RData0, 0);
    checkVal("rst_rdata1", RData1, 0);
    checkVal("rst_grant", {31'd0, Grant}, 0);
    Reset = 1'b1;
    preload(32'h10, 32'hDEADBEEF);
    preload(32'h20, 32'h0);
    preload(32'h30, 32'h0);
    preload(32'h40, 32'h11110000);
    preload(32'h44, 32'h22220000);
    preload(32'h50, 32'hCAFEF00D);
    preload(32'h54, 32'h0BADF00D);

    // ---------------- single read, port 0 ----------------
    Req0 = 1'b1; Wr0 = 1'b0; Addr0 = 32'h10;               // cycle 0
    checkVal("t1_c0_busy", {31'd0, Busy}, 0);
    tick();                                                 // cycle 1
    checkVal("t1_c1_addr", MemAddress, 32'h10);
    checkVal("t1_c1_busy", {31'd0, Busy}, 1);
    checkVal("t1_c1_ack0", {31'd0, Ack0}, 0);
    checkVal("t1_c1_memwr", {31'd0, MemWr}, 0);
    tick();                                                 // cycle 2
    checkVal("t1_c2_addr", MemAddress, 32'h10);
    checkVal("t1_c2_ack0", {31'd0, Ack0}, 0);
    tick();                                                 // cycle 3
    checkVal("t1_c3_ack0", {31'd0, Ack0}, 1);
    checkVal("t1_c3_ack1", {31'd0, Ack1}, 0);
    checkVal("t1_rdata0", RData0, 32'hDEADBEEF);
    checkVal("t1_rdata1", RData1, 0);
    Req0 = 1'b0;
    tick();                                                 // cycle 4
    checkVal("t1_c4_ack0", {31'd0, Ack0}, 0);
    checkVal("t1_c4_busy", {31'd0, Busy}, 0);

    // ---------------- write then read, port 1 ----------------
    Req1 = 1'b1; Wr1 = 1'b1; Addr1 = 32'h20; WData1 = 32'h12345678;
    tick();                                                 // cycle 1
    checkVal("t2_c1_memwr", {31'd0, MemWr}, 1);
    checkVal("t2_c1_addr", MemAddress, 32'h20);
    checkVal("t2_c1_datain", MemDatain, 32'h12345678);
    checkVal("t2_c1_ack1", {31'd0, Ack1}, 0);
    tick();                                                 // cycle 2
    checkVal("t2_c2_memwr", {31'd0, MemWr}, 0);
    checkVal("t2_c2_ack1", {31'd0, Ack1}, 1);
    checkVal("t2_c2_grant", {31'd0, Grant}, 1);
    checkVal("t2_wr_rdata1", RData1, 0);
    checkVal("t2_wr_rdata0", RData0, 32'hDEADBEEF);
    Wr1 = 1'b0;                                             // Req1 held: new read
    tick();                                                 // read cycle 0 (IDLE)
    checkVal("t2_r0_busy", {31'd0, Busy}, 0);
    checkVal("t2_r0_memwr", {31'd0, MemWr}, 0);
    tick();                                                 // read cycle 1
    checkVal("t2_r1_ack1", {31'd0, Ack1}, 0);
    tick();                                                 // read cycle 2
    checkVal("t2_r2_ack1", {31'd0, Ack1}, 0);
    tick();                                                 // read cycle 3
    checkVal("t2_r3_ack1", {31'd0, Ack1}, 1);
    checkVal("t2_rdata1", RData1, 32'h12345678);
    Req1 = 1'b0;
    tick();

    // ---------------- both ports continuously from reset ----------------
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    Req0 = 1'b1; Addr0 = 32'h40; Wr0 = 1'b0;
    Req1 = 1'b1; Addr1 = 32'h44; Wr1 = 1'b0;
    nAck = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      if (Ack0 && Ack1) checkVal("t3_both_ack", 32'd1, 32'd0);
      if (Ack0 || Ack1) begin
        checkVal("t3_order", {31'd0, Ack1}, 32'(nAck % 2));
        checkVal("t3_grant", {31'd0, Grant}, 32'(nAck % 2));
        if (Ack0) checkVal("t3_rdata0", RData0, 32'h11110000);
        else      checkVal("t3_rdata1", RData1, 32'h22220000);
        nAck++;
        if (nAck == 4) begin
          Req0 = 1'b0; Req1 = 1'b0;
          break;
        end
      end
    end
    checkVal("t3_ack_count", 32'(nAck), 4);
    tick();

    // ---------------- port 0 waits behind a port 1 read ----------------
    Req1 = 1'b1; Addr1 = 32'h44;                            // cycle 0
    tick();                                                 // cycle 1
    checkVal("t4_grant1", {31'd0, Grant}, 1);
    Req0 = 1'b1; Addr0 = 32'h40;
    tick();                                                 // cycle 2
    checkVal("t4_c2_ack0", {31'd0, Ack0}, 0);
    tick();                                                 // cycle 3
    checkVal("t4_ack1", {31'd0, Ack1}, 1);
    checkVal("t4_c3_ack0", {31'd0, Ack0}, 0);
    Req1 = 1'b0;
    tick();                                                 // IDLE, port 0 granted
    checkVal("t4_idle_busy", {31'd0, Busy}, 0);
    tick();
    checkVal("t4_p1_grant", {31'd0, Grant}, 0);
    checkVal("t4_p1_ack0", {31'd0, Ack0}, 0);
    tick();
    checkVal("t4_p2_ack0", {31'd0, Ack0}, 0);
    tick();
    checkVal("t4_p3_ack0", {31'd0, Ack0}, 1);
    checkVal("t4_rdata0", RData0, 32'h11110000);
    Req0 = 1'b0;
    tick();

    // ---------------- reset during a write ACCESS cycle ----------------
    Req0 = 1'b1; Wr0 = 1'b1; Addr0 = 32'h30; WData0 = 32'hA5A5A5A5;
    tick();                                                 // cycle 1
    checkVal("t5_memwr_on", {31'd0, MemWr}, 1);
    #2 Reset = 1'b0;
    #1;
    checkVal("t5_memwr_async", {31'd0, MemWr}, 0);
    checkVal("t5_busy_async", {31'd0, Busy}, 0);
    tick();
    checkVal("t5_no_ack0", {31'd0, Ack0}, 0);
    checkVal("t5_mem_unwritten", mem[8'h0C], 0);
    Req0 = 1'b1; Wr0 = 1'b0; Addr0 = 32'h40;
    Req1 = 1'b1; Wr1 = 1'b0; Addr1 = 32'h44;
    Reset = 1'b1;
    tick();
    checkVal("t5_tie_grant", {31'd0, Grant}, 0);
    checkVal("t5_tie_busy", {31'd0, Busy}, 1);
    tick();
    tick();
    checkVal("t5_ack0", {31'd0, Ack0}, 1);
    Req0 = 1'b0; Req1 = 1'b0;
    tick();

    // ---------------- Req0 dropped and Addr0 changed mid-read ----------------
    Req0 = 1'b1; Wr0 = 1'b0; Addr0 = 32'h50;
    tick();                                                 // cycle 1
    Req0 = 1'b0; Addr0 = 32'h54;
    #1;
    checkVal("t6_c1_addr", MemAddress, 32'h50);
    tick();                                                 // cycle 2
    checkVal("t6_c2_addr", MemAddress, 32'h50);
    checkVal("t6_c2_ack0", {31'd0, Ack0}, 0);
    tick();                                                 // cycle 3
    checkVal("t6_ack0", {31'd0, Ack0}, 1);
    checkVal("t6_rdata0", RData0, 32'hCAFEF00D);
    checkVal("t6_rdata1", RData1, 0);
    tick();
    checkVal("t6_idle_busy", {31'd0, Busy}, 0);
    checkVal("t6_no_ack0", {31'd0, Ack0}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
